// File: rtl/pipe_skid_buffer_if.sv
// pipe_skid_buffer_if: valid/ready handshake bundle for both sides of the skid buffer
interface pipe_skid_buffer_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry registered handshake buffer with synchronous flush
module pipe_skid_buffer #(parameter int WIDTH = 8) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  pipe_skid_buffer_if.slave    bus,
  output logic [1:0]           count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_main, r_skid, w_main, w_skid;
  logic             r_in_ready, r_out_valid;
  logic             w_in_fire, w_out_fire;
  assign w_in_fire     = bus.in_valid & r_in_ready;
  assign w_out_fire    = r_out_valid & bus.out_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign count         = r_state;
  // next state and register loads; flush overrides every handshake
  always_comb begin
    w_next = r_state;
    w_main = r_main;
    w_skid = r_skid;
    if (flush) w_next = EMPTY;
    else case (r_state)
      EMPTY: if (w_in_fire) begin
        w_next = ONE;
        w_main = bus.in_data;
      end
      ONE: if (w_in_fire && w_out_fire) w_main = bus.in_data;
        else if (w_in_fire) begin
          w_next = FULL;
          w_skid = bus.in_data;
        end else if (w_out_fire) w_next = EMPTY;
      FULL: if (w_out_fire) begin
        w_next = ONE;
        w_main = r_skid;
      end
      default: w_next = EMPTY;
    endcase
  end
  // state and handshake flags registered so outputs never depend on out_ready combinationally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_main      <= w_main;
      r_skid      <= w_skid;
      r_in_ready  <= w_next != FULL;
      r_out_valid <= w_next != EMPTY;
    end
  end
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: directed and random checks against a queue reference model
module tb_pipe_skid_buffer;
  logic       clk, reset_n, flush;
  logic [1:0] count;
  int         checks, failures;
  logic [7:0] q[$];
  bit         last_in_fire;
  pipe_skid_buffer_if #(.WIDTH(8)) bus ();
  pipe_skid_buffer #(.WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus.slave), .count(count));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // reference: a queue of at most two words; pop on out_fire, push on in_fire, clear on flush
  task automatic tick();
    bit inf, outf;
    inf  = bus.in_valid && (q.size() < 2);
    outf = bus.out_ready && (q.size() > 0);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(bus.in_data);
    end
    last_in_fire = !flush && inf;
    #1;
  endtask
  task automatic drain();
    bus.in_valid = 0; bus.out_ready = 1; flush = 0;
    tick(); tick();
  endtask
  task automatic test_reset();
    reset_n = 1; flush = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    #2 reset_n = 0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, count, bus.out_data} !== {1'b1, 1'b0, 2'd0, 8'h00}) begin
      failures++;
      $display("FAIL reset: got rdy=%b vld=%b cnt=%0d data=%h required 1 0 0 00", bus.in_ready, bus.out_valid, count, bus.out_data);
    end
    #1 reset_n = 1;
    q.delete();
  endtask
  task automatic test_streaming();
    bus.out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1; bus.in_data = 8'(i);
      tick();
      checks++;
      if ({bus.in_ready, bus.out_valid, count, bus.out_data} !== {1'b1, 1'b1, 2'd1, 8'(i)}) begin
        failures++;
        $display("FAIL stream[%0d]: got rdy=%b vld=%b cnt=%0d data=%h required 1 1 1 %h", i, bus.in_ready, bus.out_valid, count, bus.out_data, 8'(i));
      end
    end
    drain();
  endtask
  task automatic test_backpressure();
    logic [7:0] exp_d[6] = '{8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    logic [1:0] exp_c[6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
    logic [7:0] in_d[6]  = '{8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA3, 8'h00};
    bit         in_v[6]  = '{1, 1, 1, 1, 1, 0};
    bit         out_r[6] = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = in_v[i]; bus.in_data = in_d[i]; bus.out_ready = out_r[i];
      tick();
      checks++;
      if (count !== exp_c[i] || bus.in_ready !== (exp_c[i] != 2) || bus.out_valid !== (exp_c[i] != 0) ||
          (exp_c[i] != 0 && bus.out_data !== exp_d[i])) begin
        failures++;
        $display("FAIL backpressure[%0d]: got cnt=%0d rdy=%b vld=%b data=%h required cnt=%0d data=%h", i, count, bus.in_ready, bus.out_valid, bus.out_data, exp_c[i], exp_d[i]);
      end
    end
    drain();
  endtask
  task automatic test_simul();
    bus.in_valid = 1; bus.in_data = 8'h5A; bus.out_ready = 0;
    tick();
    bus.in_data = 8'hC3; bus.out_ready = 1;
    tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, count, bus.out_data} !== {1'b1, 1'b1, 2'd1, 8'hC3}) begin
      failures++;
      $display("FAIL simul: got rdy=%b vld=%b cnt=%0d data=%h required 1 1 1 c3", bus.in_ready, bus.out_valid, count, bus.out_data);
    end
    drain();
  endtask
  task automatic test_flush();
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_data = 8'h10; tick();
    bus.in_data = 8'h20; tick();
    flush = 1; bus.in_valid = 1; bus.in_data = 8'h77; bus.out_ready = 1;
    tick();
    checks++;
    if ({bus.in_ready, bus.out_valid, count} !== {1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL flush: got rdy=%b vld=%b cnt=%0d required 1 0 0", bus.in_ready, bus.out_valid, count);
    end
    flush = 0; bus.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || count !== 2'd0) begin
        failures++;
        $display("FAIL flush_after[%0d]: got vld=%b cnt=%0d data=%h required vld=0 cnt=0", i, bus.out_valid, count, bus.out_data);
      end
    end
  endtask
  task automatic test_reset_mid();
    bus.out_ready = 0; bus.in_valid = 1;
    bus.in_data = 8'h11; tick();
    bus.in_data = 8'h22; tick();
    checks++;
    if (count !== 2'd2 || bus.out_data !== 8'h11) begin
      failures++;
      $display("FAIL reset_mid_fill: got cnt=%0d data=%h required 2 11", count, bus.out_data);
    end
    bus.in_valid = 0;
    #1 reset_n = 0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, count, bus.out_data} !== {1'b1, 1'b0, 2'd0, 8'h00}) begin
      failures++;
      $display("FAIL reset_mid: got rdy=%b vld=%b cnt=%0d data=%h required 1 0 0 00", bus.in_ready, bus.out_valid, count, bus.out_data);
    end
    #1 reset_n = 1;
    q.delete();
    bus.in_valid = 1; bus.in_data = 8'h33;
    tick();
    checks++;
    if ({bus.out_valid, count, bus.out_data} !== {1'b1, 2'd1, 8'h33}) begin
      failures++;
      $display("FAIL reset_release: got vld=%b cnt=%0d data=%h required 1 1 33", bus.out_valid, count, bus.out_data);
    end
    drain();
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      flush = ($urandom_range(15) == 0);
      bus.out_ready = $urandom_range(1);
      if (!(bus.in_valid && !last_in_fire && !flush)) begin
        bus.in_valid = $urandom_range(1);
        bus.in_data  = 8'($urandom);
      end
      tick();
      checks++;
      if (count !== 2'(q.size()) || count == 2'd3 || bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() > 0) ||
          (q.size() > 0 && bus.out_data !== q[0])) begin
        failures++;
        $display("FAIL random[%0d]: got cnt=%0d rdy=%b vld=%b data=%h required cnt=%0d head=%h", i, count, bus.in_ready, bus.out_valid, bus.out_data, q.size(), (q.size() > 0) ? q[0] : 8'h00);
      end
    end
    drain();
  endtask
  initial begin
    checks = 0; failures = 0; last_in_fire = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simul();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
